// File: rtl/counter_nb_if.sv
// Bundle of the counter's control inputs and registered status outputs.
// The master side drives enable/mode/data; the counter sits on the slave side.
interface counter_nb_if #(
  parameter int WIDTH = 4
) ();
  logic             nb_enable;
  logic [1:0]       nb_mode;
  logic [WIDTH-1:0] nb_D;
  logic [WIDTH-1:0] nb_Q;
  logic             nb_load;
  logic             nb_rco;
  logic [7:0]       nb_wraps;
  logic [1:0]       nb_state;

  modport master (
    output nb_enable, nb_mode, nb_D,
    input  nb_Q, nb_load, nb_rco, nb_wraps, nb_state
  );

  modport slave (
    input  nb_enable, nb_mode, nb_D,
    output nb_Q, nb_load, nb_rco, nb_wraps, nb_state
  );
endinterface

// File: rtl/counter_nb.sv
// Multi-mode up/down/step/load counter with carry pulse and saturating wrap counter.
// Define COUNTER_NB_SAT_EN to clamp at the range ends instead of wrapping.
module counter_nb #(
  parameter int          WIDTH = 4,
  parameter int unsigned STEP  = 3
) (
  input  logic        nb_clk,
  input  logic        nb_reset,
  counter_nb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    LOAD  = 2'b10
  } state_t;

  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_EXT  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] Q_MAX    = '1;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             load_reg, load_next;
  logic             rco_reg, rco_next;
  logic [7:0]       wraps_reg, wraps_next;

  // One extra bit so carry/borrow out of the top is exact for any STEP.
  logic [WIDTH:0] sum_step;
  logic [WIDTH:0] sum_inc;
  logic [WIDTH:0] diff_dec;

  assign sum_step = {1'b0, q_reg} + STEP_EXT;
  assign sum_inc  = {1'b0, q_reg} + ONE_EXT;
  assign diff_dec = {1'b0, q_reg} - ONE_EXT;

  always_ff @(posedge nb_clk or negedge nb_reset) begin
    if (!nb_reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state depends only on sampled inputs, so the unused 2'b11 encoding recovers in one edge.
  always_comb begin
    state_next = IDLE;
    q_next     = q_reg;
    load_next  = 1'b0;
    rco_next   = 1'b0;
    wraps_next = wraps_reg;
    if (bus.nb_enable) begin
      case (bus.nb_mode)
        2'b00: begin
          state_next = COUNT;
          rco_next   = sum_step[WIDTH];
`ifdef COUNTER_NB_SAT_EN
          q_next = sum_step[WIDTH] ? Q_MAX : sum_step[WIDTH-1:0];
`else
          q_next = sum_step[WIDTH-1:0];
`endif
        end
        2'b01: begin
          state_next = COUNT;
          rco_next   = diff_dec[WIDTH];
`ifdef COUNTER_NB_SAT_EN
          q_next = diff_dec[WIDTH] ? '0 : diff_dec[WIDTH-1:0];
`else
          q_next = diff_dec[WIDTH-1:0];
`endif
        end
        2'b10: begin
          state_next = COUNT;
          rco_next   = sum_inc[WIDTH];
`ifdef COUNTER_NB_SAT_EN
          q_next = sum_inc[WIDTH] ? Q_MAX : sum_inc[WIDTH-1:0];
`else
          q_next = sum_inc[WIDTH-1:0];
`endif
        end
        default: begin
          state_next = LOAD;
          q_next     = bus.nb_D;
          load_next  = 1'b1;
          wraps_next = '0;
        end
      endcase
    end
    if (rco_next && (wraps_reg != 8'hFF)) begin
      wraps_next = wraps_reg + 8'd1;
    end
  end

  always_ff @(posedge nb_clk or negedge nb_reset) begin
    if (!nb_reset) begin
      q_reg     <= '0;
      load_reg  <= 1'b0;
      rco_reg   <= 1'b0;
      wraps_reg <= '0;
    end else begin
      q_reg     <= q_next;
      load_reg  <= load_next;
      rco_reg   <= rco_next;
      wraps_reg <= wraps_next;
    end
  end

  assign bus.nb_Q     = q_reg;
  assign bus.nb_load  = load_reg;
  assign bus.nb_rco   = rco_reg;
  assign bus.nb_wraps = wraps_reg;
  assign bus.nb_state = state_reg;

endmodule

// File: doc/counter_nb.md
COUNTER_NB -- requirements
Module: counter_nb

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter STEP, default 3: increment used in mode 00, legal range 1..2^WIDTH-1.
REQ-003 SHALL have port nb_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port nb_reset  input  1  asynchronous reset, active-low.
REQ-005 SHALL have port nb_enable  input  1  count enable; 0 = hold.
REQ-006 SHALL have port nb_mode  input  2  operation select: 00 +STEP, 01 -1, 10 +1, 11 parallel load.
REQ-007 SHALL have port nb_D  input  WIDTH  parallel load data.
REQ-008 SHALL have port nb_Q  output  WIDTH  registered count value.
REQ-009 SHALL have port nb_load  output  1  registered; 1 for the cycle after a load was performed.
REQ-010 SHALL have port nb_rco  output  1  registered ripple-carry/borrow pulse.
REQ-011 SHALL have port nb_wraps  output  8  registered count of nb_rco pulses since the last reset or load.
REQ-012 SHALL have port nb_state  output  2  registered FSM state: 00 IDLE, 01 COUNT, 10 LOAD.

Function
REQ-013 SHALL sample nb_enable, nb_mode and nb_D on each rising nb_clk edge; all outputs SHALL reflect the result on the same edge (latency 1 cycle, no combinational input-to-output path).
REQ-014 nb_enable=0 SHALL hold nb_Q and nb_wraps, drive nb_load=0 and nb_rco=0, and move to IDLE; nb_enable=0 overrides nb_mode.
REQ-015 Mode 00 SHALL set nb_Q <= (nb_Q+STEP) mod 2^WIDTH; nb_rco=1 iff nb_Q+STEP >= 2^WIDTH.
REQ-016 Mode 01 SHALL set nb_Q <= (nb_Q-1) mod 2^WIDTH; nb_rco=1 iff nb_Q==0 (borrow).
REQ-017 Mode 10 SHALL set nb_Q <= (nb_Q+1) mod 2^WIDTH; nb_rco=1 iff nb_Q==2^WIDTH-1.
REQ-018 Mode 11 SHALL set nb_Q <= nb_D, nb_load=1, nb_rco=0 and nb_wraps=0.
REQ-019 Modes 00/01/10 SHALL drive nb_load=0 and move to COUNT; mode 11 SHALL move to LOAD.
REQ-020 FSM transitions SHALL be a pure function of the sampled inputs: any state goes to IDLE, COUNT or LOAD per REQ-014/REQ-019, in one cycle, with no illegal-state lockup (encoding 11 SHALL recover to IDLE on the next edge).
REQ-021 nb_wraps SHALL increment on every cycle that sets nb_rco=1 and SHALL saturate at 255.
REQ-022 Arithmetic SHALL use WIDTH+1 bits internally so that the carry of REQ-015 is exact for any STEP.

Reset
REQ-023 nb_reset=0 SHALL immediately, without waiting for a clock edge, force nb_Q=0, nb_load=0, nb_rco=0, nb_wraps=0 and nb_state=IDLE.
REQ-024 Reset asserted mid-count SHALL discard the operation in progress; the first edge after release SHALL perform a normal operation from nb_Q=0.

Configuration
REQ-025 Macro COUNTER_NB_SAT_EN SHALL select saturating arithmetic when defined: mode 00/10 clamp nb_Q at 2^WIDTH-1, mode 01 clamps at 0, and nb_rco=1 on every cycle in which clamping occurred.
REQ-026 Without COUNTER_NB_SAT_EN the block SHALL wrap modulo 2^WIDTH as in REQ-015..REQ-017.

Verification
REQ-027 Reset 0, release, enable=1, mode 10 for 17 cycles (WIDTH=4) -> nb_Q 1..15,0,1; nb_rco=1 only on the cycle nb_Q becomes 0; nb_wraps=1.
REQ-028 Load D=4'hE (mode 11), then mode 00 one cycle -> nb_Q=E, nb_load=1, nb_state=10, then nb_Q=1, nb_rco=1, nb_load=0, nb_state=01.
REQ-029 nb_Q=0, mode 01 -> nb_Q=F, nb_rco=1; with COUNTER_NB_SAT_EN -> nb_Q=0, nb_rco=1.
REQ-030 nb_Q=7, enable=0 with mode 11 and D=2 for 3 cycles -> nb_Q stays 7, nb_load=0, nb_rco=0, nb_state=00.
REQ-031 Count mode 10 from 5, drop nb_reset between edges -> nb_Q=0, nb_wraps=0, nb_state=00 before the next edge.
REQ-032 WIDTH=8, STEP=100, mode 00 from 0 for 3 cycles -> nb_Q 100, 200, 44; nb_rco=1 on the third cycle only.
